// File: rtl/sha_host_ctrl_if.sv
// sha_host_ctrl_if
//   Bundles every non-clock, non-reset signal of the SHA-256 host controller.
//   The signal names match the controller's external pin names.
//   - master: the controller side (sha_host_ctrl).
//   - slave : the environment side (command source, core, output memory,
//     digest sink).
//   Signal groups:
//     command : cmd_valid, cmd_ready, cmd_msg_length, cmd_err, busy
//     core    : host__dut__go, host__dut__msg_length, dut__host__finish
//     out mem : host__dom__address, host__dom__enable, host__dom__write,
//               dom__host__data
//     digest  : dig_valid, dig_ready, dig_data, dig_last
//   Handshake rule for cmd_* and dig_*:
//     - A transfer happens on a rising clock edge where valid and ready are
//       both high.
//     - The producer holds valid and its payload steady until that transfer.
interface sha_host_ctrl_if #(
    parameter int OUTPUT_LENGTH      = 8,
    parameter int MAX_MESSAGE_LENGTH = 55
);
    localparam int AW = $clog2(OUTPUT_LENGTH);
    localparam int LW = $clog2(MAX_MESSAGE_LENGTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_msg_length;
    logic          cmd_err;
    logic          busy;

    logic          host__dut__go;
    logic [LW-1:0] host__dut__msg_length;
    logic          dut__host__finish;

    logic [AW-1:0] host__dom__address;
    logic          host__dom__enable;
    logic          host__dom__write;
    logic [31:0]   dom__host__data;

    logic          dig_valid;
    logic          dig_ready;
    logic [31:0]   dig_data;
    logic          dig_last;

    modport master (
        input  cmd_valid, cmd_msg_length, dut__host__finish, dom__host__data, dig_ready,
        output cmd_ready, cmd_err, busy, host__dut__go, host__dut__msg_length,
               host__dom__address, host__dom__enable, host__dom__write,
               dig_valid, dig_data, dig_last
    );

    modport slave (
        output cmd_valid, cmd_msg_length, dut__host__finish, dom__host__data, dig_ready,
        input  cmd_ready, cmd_err, busy, host__dut__go, host__dut__msg_length,
               host__dom__address, host__dom__enable, host__dom__write,
               dig_valid, dig_data, dig_last
    );
endinterface

// File: rtl/sha_host_ctrl.sv
// sha_host_ctrl
//   Host-side controller for the SHA-256 core. It performs one hash run per
//   accepted command:
//     1. Accept a command carrying the message length.
//     2. Pulse the core's go and present the latched length.
//     3. Wait for a fresh rising edge of the core's finish.
//     4. Read the OUTPUT_LENGTH digest words from the output data memory.
//     5. Stream those words out over a valid/ready port, H0 first.
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous, active-low; forces IDLE and zeroes all outputs
//     bus          sha_host_ctrl_if.master (command, core, output memory,
//                  digest stream)
//     dbg_state_o  current FSM state
module sha_host_ctrl #(
    parameter int OUTPUT_LENGTH      = 8,
    parameter int MAX_MESSAGE_LENGTH = 55
) (
    input  logic                    clk,
    input  logic                    reset,
    sha_host_ctrl_if.master         bus,
    output logic [2:0]              dbg_state_o
);
    localparam int AW = $clog2(OUTPUT_LENGTH);
    localparam int LW = $clog2(MAX_MESSAGE_LENGTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_FIN = 3'd2,
        S_RD_REQ   = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_SEND     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;
    logic          finish_q;
    // Holds cmd_ready low until the first edge after reset is released.
    logic          ready_en_q;

    logic finish_rise;
    logic last_word;
    logic len_legal;

    // A finish level left over from an earlier run is not a new completion.
    // Only a 0->1 transition counts.
    assign finish_rise = bus.dut__host__finish && !finish_q;
    assign last_word   = (idx_q == AW'(OUTPUT_LENGTH - 1));
    assign len_legal   = (bus.cmd_msg_length != '0) &&
                         (bus.cmd_msg_length <= LW'(MAX_MESSAGE_LENGTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            finish_q   <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            data_q     <= data_d;
            err_q      <= err_d;
            finish_q   <= bus.dut__host__finish;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ready_en_q && bus.cmd_valid) begin
                    if (len_legal) begin
                        len_d   = bus.cmd_msg_length;
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        // An illegal command is consumed and only flagged.
                        err_d = 1'b1;
                    end
                end
            end
            S_START:    state_d = S_WAIT_FIN;
            S_WAIT_FIN: if (finish_rise) state_d = S_RD_REQ;
            S_RD_REQ:   state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                // The memory returns data one cycle after enable.
                data_d  = bus.dom__host__data;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.dig_ready) begin
                    if (last_word) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_RD_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from registered state only. Reset therefore drives
    // them to zero immediately.
    assign bus.cmd_ready             = ready_en_q && (state_q == S_IDLE);
    assign bus.cmd_err               = err_q;
    assign bus.busy                  = (state_q != S_IDLE);
    assign bus.host__dut__go         = (state_q == S_START);
    assign bus.host__dut__msg_length = len_q;
    assign bus.host__dom__enable     = (state_q == S_RD_REQ);
    assign bus.host__dom__address    = (state_q == S_RD_REQ) ? idx_q : '0;
    assign bus.host__dom__write      = 1'b0;
    assign bus.dig_valid             = (state_q == S_SEND);
    assign bus.dig_data              = data_q;
    assign bus.dig_last              = (state_q == S_SEND) && last_word;
    assign dbg_state_o               = state_q;
endmodule

// File: tb/tb_sha_host_ctrl.sv
module tb_sha_host_ctrl;
    localparam int OL = 8;
    localparam int ML = 55;
    localparam int AW = $clog2(OL);
    localparam int LW = $clog2(ML) + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;

    sha_host_ctrl_if #(.OUTPUT_LENGTH(OL), .MAX_MESSAGE_LENGTH(ML)) bus();

    sha_host_ctrl #(.OUTPUT_LENGTH(OL), .MAX_MESSAGE_LENGTH(ML)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.master),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory / core models ----------------
    logic [31:0]   mem [OL];
    logic [31:0]   exp_q [$];
    logic [AW-1:0] rd_log [$];
    int            rd_cnt = 0;
    int            go_cnt = 0;
    int            total  = 0;
    int            bad    = 0;

    always @(posedge clk) begin
        if (bus.host__dom__enable) begin
            bus.dom__host__data <= mem[bus.host__dom__address];
            rd_cnt              <= rd_cnt + 1;
            rd_log.push_back(bus.host__dom__address);
        end
        if (bus.host__dut__go) go_cnt <= go_cnt + 1;
    end

    function automatic logic [39+LW+AW:0] outs();
        return {bus.cmd_ready, bus.cmd_err, bus.busy, bus.host__dut__go,
                bus.host__dut__msg_length, bus.host__dom__address,
                bus.host__dom__enable, bus.host__dom__write, bus.dig_valid,
                bus.dig_data, bus.dig_last};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_random_mem();
        for (int i = 0; i < OL; i++) mem[i] = $urandom;
    endtask

    // Called at a negedge in IDLE. Returns at the negedge of T+2 (WAIT_FIN).
    task automatic issue_cmd(input logic [LW-1:0] len);
        int g0;
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1)
            $display("FAIL cmd_ready_idle got=%b exp=1", bus.cmd_ready);
        if (bus.cmd_ready !== 1'b1) bad++;
        bus.cmd_valid      = 1'b1;
        bus.cmd_msg_length = len;
        g0 = go_cnt;
        for (int i = 0; i < OL; i++) exp_q.push_back(mem[i]);
        rd_log.delete();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        total++;
        if ({bus.host__dut__go, bus.host__dut__msg_length, bus.busy, bus.cmd_ready} !== {1'b1, len, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL go_t1 go=%b len=%0d busy=%b rdy=%b exp go=1 len=%0d busy=1 rdy=0",
                     bus.host__dut__go, bus.host__dut__msg_length, bus.busy, bus.cmd_ready, len);
        end
        @(negedge clk);
        total++;
        if (bus.host__dut__go !== 1'b0 || go_cnt !== g0 + 1) begin
            bad++;
            $display("FAIL go_once go=%b pulses=%0d exp go=0 pulses=%0d", bus.host__dut__go, go_cnt - g0, 1);
        end
    endtask

    // Called at a negedge. Raises finish so that the current cycle is F.
    // c counts cycles after F. Returns early once stop_after words are done
    // and the next word is valid.
    task automatic collect(input int rand_ready, input int stop_after,
                           output int last_hs, output int idle_at,
                           output int stalls, output int hs);
        int          c;
        logic        rdy;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [31:0] exp;
        c = 0; hs = 0; stalls = 0; last_hs = -1; idle_at = -1;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        bus.dut__host__finish = 1'b1;
        while (c < 400) begin
            @(negedge clk);
            c++;
            if (prev_stall) begin
                total++;
                if (bus.dig_valid !== 1'b1 || bus.dig_data !== prev_data || bus.dig_last !== prev_last) begin
                    bad++;
                    $display("FAIL stall_hold valid=%b data=%h last=%b exp valid=1 data=%h last=%b",
                             bus.dig_valid, bus.dig_data, bus.dig_last, prev_data, prev_last);
                end
            end
            if (stop_after > 0 && hs == stop_after && bus.dig_valid === 1'b1) begin
                bus.dig_ready = 1'b0;
                return;
            end
            if (bus.cmd_ready === 1'b1) begin
                idle_at = c;
                break;
            end
            rdy = rand_ready != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.dig_ready = rdy;
            prev_stall = 1'b0;
            if (bus.dig_valid === 1'b1) begin
                if (rdy) begin
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    total++;
                    if (bus.dig_data !== exp) begin
                        bad++;
                        $display("FAIL word%0d_data got=%h exp=%h", hs, bus.dig_data, exp);
                    end
                    total++;
                    if (bus.dig_last !== (hs == OL - 1)) begin
                        bad++;
                        $display("FAIL word%0d_last got=%b exp=%b", hs, bus.dig_last, hs == OL - 1);
                    end
                    hs++;
                    last_hs = c;
                end else begin
                    stalls++;
                    prev_stall = 1'b1;
                    prev_data  = bus.dig_data;
                    prev_last  = bus.dig_last;
                end
            end
        end
        bus.dig_ready = 1'b0;
        total++;
        if (idle_at < 0 || hs != OL || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stream_end idle_at=%0d words=%0d left=%0d exp words=%0d left=0",
                     idle_at, hs, exp_q.size(), OL);
        end
        total++;
        if (rd_log.size() != OL) begin
            bad++;
            $display("FAIL read_count got=%0d exp=%0d", rd_log.size(), OL);
        end else begin
            for (int i = 0; i < OL; i++) begin
                total++;
                if (rd_log[i] !== AW'(i)) begin
                    bad++;
                    $display("FAIL read_addr%0d got=%0d exp=%0d", i, rd_log[i], i);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL reset_outs got=%h exp=0", outs());
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%b exp=0", bus.cmd_ready);
        end
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_release rdy=%b busy=%b exp rdy=1 busy=0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        int r0, lh, ia, st, hs;
        mem[0] = 32'hBA7816BF; mem[1] = 32'h8F01CFEA; mem[2] = 32'h414140DE; mem[3] = 32'h5DAE2223;
        mem[4] = 32'hB00361A3; mem[5] = 32'h96177A9C; mem[6] = 32'hB410FF61; mem[7] = 32'hF20015AD;
        issue_cmd(LW'(3));
        r0 = rd_cnt;
        repeat (39) @(negedge clk);
        total++;
        if (rd_cnt !== r0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_wait reads=%0d busy=%b exp reads=0 busy=1", rd_cnt - r0, bus.busy);
        end
        collect(0, 0, lh, ia, st, hs);
        total++;
        if (lh !== 24 || ia !== 25) begin
            bad++;
            $display("FAIL basic_timing last_hs=F+%0d idle=F+%0d exp F+24 F+25", lh, ia);
        end
    endtask

    task automatic test_stale_finish();
        int r0, lh, ia, st, hs;
        load_random_mem();
        issue_cmd(LW'(10));
        r0 = rd_cnt;
        repeat (20) @(negedge clk);
        total++;
        if (rd_cnt !== r0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL stale_ignored reads=%0d busy=%b exp reads=0 busy=1", rd_cnt - r0, bus.busy);
        end
        bus.dut__host__finish = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (rd_cnt !== r0) begin
            bad++;
            $display("FAIL stale_low reads=%0d exp=0", rd_cnt - r0);
        end
        collect(0, 0, lh, ia, st, hs);
        total++;
        if (lh !== 24 || ia !== 25) begin
            bad++;
            $display("FAIL stale_timing last_hs=F+%0d idle=F+%0d exp F+24 F+25", lh, ia);
        end
    endtask

    task automatic test_backpressure();
        int lh, ia, st, hs;
        bus.dut__host__finish = 1'b0;
        load_random_mem();
        issue_cmd(LW'(17));
        repeat (4) @(negedge clk);
        collect(1, 0, lh, ia, st, hs);
        total++;
        if (lh !== 24 + st || ia !== lh + 1) begin
            bad++;
            $display("FAIL bp_timing last_hs=F+%0d idle=F+%0d exp F+%0d F+%0d", lh, ia, 24 + st, 25 + st);
        end
    endtask

    task automatic test_illegal();
        logic [LW-1:0] bad_len [3];
        int g0, lh, ia, st, hs;
        bad_len[0] = LW'(0); bad_len[1] = LW'(56); bad_len[2] = LW'(127);
        bus.dut__host__finish = 1'b0;
        g0 = go_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.cmd_valid      = 1'b1;
            bus.cmd_msg_length = bad_len[i];
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            total++;
            if ({bus.cmd_err, bus.busy, bus.host__dut__go, bus.cmd_ready} !== 4'b1001) begin
                bad++;
                $display("FAIL illegal%0d err=%b busy=%b go=%b rdy=%b exp 1 0 0 1",
                         bad_len[i], bus.cmd_err, bus.busy, bus.host__dut__go, bus.cmd_ready);
            end
            @(negedge clk);
            total++;
            if (bus.cmd_err !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL illegal%0d_pulse err=%b busy=%b exp 0 0", bad_len[i], bus.cmd_err, bus.busy);
            end
        end
        total++;
        if (go_cnt !== g0) begin
            bad++;
            $display("FAIL illegal_no_go pulses=%0d exp=0", go_cnt - g0);
        end
        load_random_mem();
        issue_cmd(LW'(55));
        repeat (2) @(negedge clk);
        collect(0, 0, lh, ia, st, hs);
        total++;
        if (lh !== 24 || ia !== 25) begin
            bad++;
            $display("FAIL len55_timing last_hs=F+%0d idle=F+%0d exp F+24 F+25", lh, ia);
        end
    endtask

    task automatic test_reset_mid();
        int lh, ia, st, hs;
        bus.dut__host__finish = 1'b0;
        load_random_mem();
        issue_cmd(LW'(20));
        repeat (5) @(negedge clk);
        collect(0, 4, lh, ia, st, hs);
        total++;
        if (hs !== 4 || bus.dig_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_position words=%0d valid=%b exp words=4 valid=1", hs, bus.dig_valid);
        end
        reset = 1'b0;
        bus.dut__host__finish = 1'b0;
        #1;
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL mid_reset_outs got=%h exp=0", outs());
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load_random_mem();
        issue_cmd(LW'(1));
        repeat (3) @(negedge clk);
        collect(0, 0, lh, ia, st, hs);
        total++;
        if (lh !== 24 || ia !== 25) begin
            bad++;
            $display("FAIL after_reset_timing last_hs=F+%0d idle=F+%0d exp F+24 F+25", lh, ia);
        end
    endtask

    task automatic test_idle_noise();
        int r0, g0, errs, lh, ia, st, hs;
        bus.dut__host__finish = 1'b0;
        @(negedge clk);
        r0 = rd_cnt;
        g0 = go_cnt;
        for (int i = 0; i < 6; i++) begin
            bus.dut__host__finish = ~bus.dut__host__finish;
            @(negedge clk);
        end
        bus.dut__host__finish = 1'b0;
        @(negedge clk);
        total++;
        if (rd_cnt !== r0 || go_cnt !== g0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_finish reads=%0d gos=%0d busy=%b rdy=%b exp 0 0 0 1",
                     rd_cnt - r0, go_cnt - g0, bus.busy, bus.cmd_ready);
        end
        load_random_mem();
        issue_cmd(LW'(5));
        errs = 0;
        bus.cmd_valid      = 1'b1;
        bus.cmd_msg_length = LW'(7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.cmd_ready !== 1'b0 || bus.host__dut__msg_length !== LW'(5) || bus.host__dut__go !== 1'b0) errs++;
        end
        bus.cmd_valid = 1'b0;
        total++;
        if (errs != 0 || go_cnt !== g0 + 1) begin
            bad++;
            $display("FAIL busy_cmd bad_cycles=%0d gos=%0d exp 0 1", errs, go_cnt - g0);
        end
        collect(0, 0, lh, ia, st, hs);
        total++;
        if (lh !== 24 || ia !== 25 || bus.host__dut__msg_length !== LW'(5)) begin
            bad++;
            $display("FAIL busy_cmd_run last_hs=F+%0d idle=F+%0d len=%0d exp F+24 F+25 5",
                     lh, ia, bus.host__dut__msg_length);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.cmd_valid         = 1'b0;
        bus.cmd_msg_length    = '0;
        bus.dut__host__finish = 1'b0;
        bus.dig_ready         = 1'b0;
        bus.dom__host__data   = '0;
        reset                 = 1'b0;
        for (int i = 0; i < OL; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_stale_finish();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_idle_noise();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
